// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_defs (package)
// Purpose  : Shared types and constants for the instruction-fetch front end.
// Revision : 1.0
// ============================================================================
package fetch_defs;

  // Fetch FSM: nothing outstanding / outstanding & kept / outstanding & dropped
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INST_W           = 32;

  // One buffered fetch: the instruction together with the PC it came from
  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Purpose  : Memory request/response, redirect and instruction handshake
//            bundle between the fetch unit (master) and its environment.
// Revision : 1.0
// ============================================================================
interface fetch_if;
  import fetch_defs::*;

  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [31:0]       inst_pc;
  logic [31:0]       inst_pc4;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_pc4,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_pc4,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous FIFO of {pc, inst} entries with flush.
//            Depth must be a power of two so the pointers wrap naturally.
// Revision : 1.0
// ============================================================================
module fetch_fifo
  import fetch_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                   clock,
  input  wire logic                   reset_n,
  input  wire logic                   push_i,
  input  wire logic                   pop_i,
  input  wire logic                   flush_i,
  input  wire fifo_entry_t            wdata_i,
  output logic [$clog2(DEPTH):0]      count_o,
  output fifo_entry_t                 head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t     mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  // Pointer and occupancy bookkeeping; flush discards everything at once
  always_ff @(posedge clock) begin
    if (!reset_n || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; stale contents are never visible because count gates reads
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Program counter, single-outstanding fetch FSM and redirect
//            handling in front of a small instruction buffer.
// Revision : 1.0
// ============================================================================
module fetch_unit
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  wire logic clock,
  input  wire logic reset_n,
  fetch_if.master   bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;

  logic [CW-1:0] count;
  fifo_entry_t   head;
  fifo_entry_t   wentry;
  logic          inst_valid;
  logic          push, pop, credit, issue;
  logic [OW-1:0] occ;

  assign inst_valid = (count != '0);
  assign wentry     = '{pc: req_pc_q, inst: bus.imem_rdata};

  // State, PC and in-flight request PC registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // Next-state, issue decision and buffer control; redirect dominates
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;

    push = bus.imem_rvalid && (state_q == ST_WAIT) && !bus.redirect_valid;
    pop  = inst_valid && bus.inst_ready && !bus.redirect_valid;
    // Reserve a slot for the response of any request we issue now
    occ    = OW'(count) + OW'(push) + OW'(1) - OW'(pop);
    credit = (occ <= OW'(FIFO_DEPTH));
    issue  = reset_n && !bus.redirect_valid && credit &&
             ((state_q == ST_IDLE) || bus.imem_rvalid);

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~32'h0000_0003;
      // A request still in flight must have its response thrown away
      state_d = ((state_q != ST_IDLE) && !bus.imem_rvalid) ? ST_DROP : ST_IDLE;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
      state_d    = ST_WAIT;
    end else if ((state_q != ST_IDLE) && bus.imem_rvalid) begin
      state_d = ST_IDLE;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .wdata_i (wentry),
    .count_o (count),
    .head_o  (head)
  );

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = issue ? fetch_pc_q : 32'h0;
  assign bus.inst_valid = inst_valid;
  assign bus.inst_data  = inst_valid ? head.inst : '0;
  assign bus.inst_pc    = inst_valid ? head.pc : 32'h0;
  assign bus.inst_pc4   = inst_valid ? (head.pc + 32'd4) : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed + random bench for fetch_unit with a queue-based model
//            of the fetch buffer and a variable-latency memory.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] C_RESET_PC = 32'hFFFF_FFFC;
  localparam int          C_DEPTH    = 2;

  logic clock;
  logic reset_n;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC   (C_RESET_PC),
    .FIFO_DEPTH (C_DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_opc;
  bit          m_out;
  bit          m_drop;

  // Memory model state; lat==0 means a random latency of 1..4 per request
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat;

  int vectors;
  int miscompares;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    assert (act === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance memory and model
  task automatic step(input bit rn, input bit rd, input logic [31:0] tgt, input bit rdy);
    bit          rv;
    bit          e_v, push, pop, issue;
    int          occ;
    logic [31:0] e_d, e_p;

    reset_n = rn;
    rv = 1'b0;
    if (!rn) begin
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
      rv = (mem_cnt == 0);
    end
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rv ? mem_word(mem_addr) : $urandom();
    bus.redirect_valid = rd;
    bus.redirect_pc    = tgt;
    bus.inst_ready     = rdy;
    #1;

    e_v   = (mq.size() != 0);
    e_d   = e_v ? mq[0].inst : 32'h0;
    e_p   = e_v ? mq[0].pc : 32'h0;
    push  = rn && rv && m_out && !m_drop && !rd;
    pop   = e_v && rdy && !rd;
    occ   = mq.size() + int'(push) - int'(pop) + 1;
    issue = rn && !rd && (occ <= C_DEPTH) && (!m_out || rv);

    chk("imem_req",   32'(bus.imem_req),   32'(issue));
    chk("imem_addr",  bus.imem_addr,       issue ? m_fpc : 32'h0);
    chk("inst_valid", 32'(bus.inst_valid), 32'(e_v));
    chk("inst_data",  bus.inst_data,       e_d);
    chk("inst_pc",    bus.inst_pc,         e_p);
    chk("inst_pc4",   bus.inst_pc4,        e_v ? e_p + 32'd4 : 32'h0);
    assert (dut.u_fifo.count_q <= C_DEPTH)
    else begin
      miscompares++;
      $error("FAIL fifo_bound: observed %0d expected <= %0d", dut.u_fifo.count_q, C_DEPTH);
    end

    if (rv) mem_busy = 1'b0;
    if (rn && bus.imem_req === 1'b1) begin
      mem_busy = 1'b1;
      mem_cnt  = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
      mem_addr = bus.imem_addr;
    end

    if (!rn) begin
      mq.delete();
      m_fpc  = C_RESET_PC;
      m_out  = 1'b0;
      m_drop = 1'b0;
    end else if (rd) begin
      mq.delete();
      m_fpc  = {tgt[31:2], 2'b00};
      if (rv) m_out = 1'b0;
      m_drop = 1'b1;
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back('{pc: m_opc, inst: mem_word(m_opc)});
      if (rv)   m_out = 1'b0;
      if (issue) begin
        m_out  = 1'b1;
        m_drop = 1'b0;
        m_opc  = m_fpc;
        m_fpc  = m_fpc + 32'd4;
      end
    end

    @(posedge clock);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mem_busy    = 1'b0;
    mem_cnt     = 0;
    mem_addr    = 32'h0;
    lat         = 1;
    m_fpc       = C_RESET_PC;
    m_opc       = 32'h0;
    m_out       = 1'b0;
    m_drop      = 1'b0;
    reset_n            = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state, then streaming with 1-cycle memory (wraps past 0xFFFFFFFC)
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Consumer stall: buffer fills to depth, head held, then drains
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("stall_count", 32'(dut.u_fifo.count_q), 32'd2);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect to 0x43 while a 3-cycle request is outstanding
    step(1'b0, 1'b0, 32'h0, 1'b1);
    lat = 3;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0043, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect coinciding with a response and a ready consumer
    lat = 1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Reset mid-WAIT with one buffered entry
    step(1'b0, 1'b0, 32'h0, 1'b0);
    lat = 3;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("pre_reset_count", 32'(dut.u_fifo.count_q), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("post_reset_count", 32'(dut.u_fifo.count_q), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Random traffic: latency, backpressure, redirects and occasional reset
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0,
           $urandom(), $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
